// File: rtl/mem_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pipe_reg
// Description : MEM->WB pipeline register with stall/flush, sticky halt FSM,
//               retired-instruction counter and forwarding-valid tap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_pipe_reg #(
    parameter int DATA_W = 16,
    parameter int TGT_W  = 3,
    parameter int OPC_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              bubble_in,
    input  logic [OPC_W-1:0]  opcode_in,
    input  logic [TGT_W-1:0]  tgt_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              halt_in,
    output logic [OPC_W-1:0]  opcode_out,
    output logic [TGT_W-1:0]  tgt_out,
    output logic [DATA_W-1:0] result_out,
    output logic              bubble_out,
    output logic              halt_out,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_count,
    output logic              fwd_valid
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_HALTING = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t              r_state, w_state_nxt;
    logic [OPC_W-1:0]    r_opc,   w_opc_nxt;
    logic [TGT_W-1:0]    r_tgt,   w_tgt_nxt;
    logic [DATA_W-1:0]   r_res,   w_res_nxt;
    logic                r_bub,   w_bub_nxt;
    logic                r_halt,  w_halt_nxt;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
    logic                w_load_halt;

    assign w_load_halt = halt_in & ~bubble_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_opc   <= '0;
            r_tgt   <= '0;
            r_res   <= '0;
            r_bub   <= 1'b1;
            r_halt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_opc   <= w_opc_nxt;
            r_tgt   <= w_tgt_nxt;
            r_res   <= w_res_nxt;
            r_bub   <= w_bub_nxt;
            r_halt  <= w_halt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_opc_nxt   = r_opc;
        w_tgt_nxt   = r_tgt;
        w_res_nxt   = r_res;
        w_bub_nxt   = r_bub;
        w_halt_nxt  = r_halt;
        w_cnt_nxt   = r_cnt;

        if (r_state == S_HALTED || flush || (!stall && r_state == S_HALTING)) begin
            // Internally inserted bubble: data fields are zeroed.
            w_opc_nxt  = '0;
            w_tgt_nxt  = '0;
            w_res_nxt  = '0;
            w_bub_nxt  = 1'b1;
            w_halt_nxt = 1'b0;
            if (r_state == S_HALTING) begin
                w_state_nxt = S_HALTED;
            end
        end else if (!stall) begin
            // Ordinary load in RUN; passed-through bubbles keep their fields.
            w_opc_nxt  = opcode_in;
            w_tgt_nxt  = tgt_in;
            w_res_nxt  = result_in;
            w_bub_nxt  = bubble_in;
            w_halt_nxt = w_load_halt;
            if (w_load_halt) begin
                w_state_nxt = S_HALTING;
            end
            if (!bubble_in) begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
        end
    end

    assign opcode_out    = r_opc;
    assign tgt_out       = r_tgt;
    assign result_out    = r_res;
    assign bubble_out    = r_bub;
    assign halt_out      = r_halt;
    assign halted        = (r_state == S_HALTED);
    assign retired_count = r_cnt;
    assign fwd_valid     = ~r_bub & (r_tgt != '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_pipe_reg
// Description : Directed plus random bench against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_pipe_reg;

    localparam int DATA_W = 16;
    localparam int TGT_W  = 3;
    localparam int OPC_W  = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, stall, flush, bubble_in, halt_in;
    logic [OPC_W-1:0]  opcode_in;
    logic [TGT_W-1:0]  tgt_in;
    logic [DATA_W-1:0] result_in;
    logic [OPC_W-1:0]  opcode_out;
    logic [TGT_W-1:0]  tgt_out;
    logic [DATA_W-1:0] result_out;
    logic              bubble_out, halt_out, halted, fwd_valid;
    logic [CNT_W-1:0]  retired_count;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: mode 0 = running, 1 = halt retiring, 2 = halted.
    int unsigned m_opc, m_tgt, m_res, m_cnt;
    int          m_mode;
    bit          m_bub, m_halt;

    mem_stage_pipe_reg #(
        .DATA_W(DATA_W), .TGT_W(TGT_W), .OPC_W(OPC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .bubble_in(bubble_in), .opcode_in(opcode_in), .tgt_in(tgt_in),
        .result_in(result_in), .halt_in(halt_in),
        .opcode_out(opcode_out), .tgt_out(tgt_out), .result_out(result_out),
        .bubble_out(bubble_out), .halt_out(halt_out), .halted(halted),
        .retired_count(retired_count), .fwd_valid(fwd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_insert_bubble();
        m_opc = 0; m_tgt = 0; m_res = 0; m_bub = 1; m_halt = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_insert_bubble();
            m_mode = 0;
            m_cnt  = 0;
        end else if (m_mode == 2) begin
            model_insert_bubble();
        end else if (flush) begin
            model_insert_bubble();
            if (m_mode == 1) m_mode = 2;
        end else if (stall) begin
            // everything holds
        end else if (m_mode == 1) begin
            model_insert_bubble();
            m_mode = 2;
        end else begin
            m_opc  = opcode_in;
            m_tgt  = tgt_in;
            m_res  = result_in;
            m_bub  = bubble_in;
            m_halt = halt_in && !bubble_in;
            if (m_halt) m_mode = 1;
            if (!bubble_in) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".opcode"}, 32'(opcode_out), m_opc);
        chk({tag, ".tgt"},    32'(tgt_out),    m_tgt);
        chk({tag, ".result"}, 32'(result_out), m_res);
        chk({tag, ".bubble"}, 32'(bubble_out), 32'(m_bub));
        chk({tag, ".halt"},   32'(halt_out),   32'(m_halt));
        chk({tag, ".halted"}, 32'(halted),     32'(m_mode == 2));
        chk({tag, ".count"},  32'(retired_count), m_cnt);
        chk({tag, ".fwd"},    32'(fwd_valid),  32'(!m_bub && m_tgt != 0));
    endtask

    task automatic step(input string tag, input bit r, input bit st, input bit fl,
                        input bit bub, input int unsigned opc, input int unsigned tgt,
                        input int unsigned res, input bit hlt);
        rst = r; stall = st; flush = fl; bubble_in = bub; halt_in = hlt;
        opcode_in = OPC_W'(opc); tgt_in = TGT_W'(tgt); result_in = DATA_W'(res);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; bubble_in = 1; halt_in = 0;
        opcode_in = '0; tgt_in = '0; result_in = '0;
        m_mode = 0; m_cnt = 0; model_insert_bubble();
        @(negedge clk);

        // Reset state
        step("reset", 1, 0, 0, 0, 7, 7, 16'h1234, 1);

        // 1: single load
        step("load", 0, 0, 0, 0, 3, 5, 16'hBEEF, 0);
        chk("load.fwd_direct", 32'(fwd_valid), 32'd1);
        chk("load.res_direct", 32'(result_out), 32'hBEEF);

        // 2: stall three cycles with changing inputs, then resume
        step("stall1", 0, 1, 0, 0, 1, 2, 16'h1111, 0);
        step("stall2", 0, 1, 0, 0, 2, 3, 16'h2222, 0);
        step("stall3", 0, 1, 0, 1, 4, 4, 16'h3333, 1);
        step("resume", 0, 0, 0, 0, 6, 1, 16'h4444, 0);

        // 3: flush overrides stall
        step("flush", 0, 1, 1, 0, 5, 6, 16'h5555, 0);
        chk("flush.tgt_direct", 32'(tgt_out), 32'd0);

        // Pass-through bubble keeps data, halt on bubble ignored
        step("passbub", 0, 0, 0, 1, 2, 7, 16'hABCD, 1);
        step("after_passbub", 0, 0, 0, 0, 1, 0, 16'h0F0F, 0);

        // 4: halt retires, pipeline drains, halted is sticky
        step("halt", 0, 0, 0, 0, 7, 2, 16'h00FF, 1);
        step("halting", 0, 0, 0, 0, 3, 3, 16'h0101, 0);
        step("halted1", 0, 0, 0, 0, 3, 3, 16'h0202, 0);
        step("halted2", 0, 1, 1, 0, 4, 4, 16'h0303, 1);

        // 5: halt followed by stall holds halt_out
        step("rst5", 1, 0, 0, 0, 0, 0, 0, 0);
        step("halt5", 0, 0, 0, 0, 1, 1, 16'h7777, 1);
        step("halt5_st1", 0, 1, 0, 0, 2, 2, 16'h8888, 0);
        step("halt5_st2", 0, 1, 0, 0, 2, 2, 16'h8888, 0);
        step("halt5_go", 0, 0, 0, 0, 2, 2, 16'h9999, 0);
        step("halt5_sticky", 0, 0, 0, 0, 2, 2, 16'h9999, 0);

        // Flush during HALTING moves straight to HALTED
        step("rst5b", 1, 0, 0, 0, 0, 0, 0, 0);
        step("halt5b", 0, 0, 0, 0, 1, 4, 16'h4242, 1);
        step("halt5b_fl", 0, 1, 1, 0, 1, 4, 16'h4242, 0);

        // 6: counter wrap with CNT_W=4, then reset mid-HALTING
        step("rst6", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step("wrap", 0, 0, 0, 0, i % 8, i % 8, i * 16'h0101, 0);
        chk("wrap.count_zero", 32'(retired_count), 32'd0);
        step("halt6", 0, 0, 0, 0, 5, 5, 16'hCAFE, 1);
        step("rst_mid_halting", 1, 0, 0, 0, 5, 5, 16'hCAFE, 1);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bit r, st, fl, bub, hlt;
            r   = ($urandom_range(0, 39) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            bub = ($urandom_range(0, 4) == 0);
            hlt = ($urandom_range(0, 19) == 0);
            step("rand", r, st, fl, bub, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 65535), hlt);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
